// File: rtl/dm_store_buffer_pkg.sv
// Shared sizing constants for the data-memory store buffer.
package dm_store_buffer_pkg;

    localparam int SB_DEPTH = 4;
    localparam int SB_AW    = 8;
    localparam int SB_DW    = 16;

    function automatic int sb_ptr_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/sb_fwd_match.sv
// Youngest-match search over the valid store-buffer entries for load forwarding.
module sb_fwd_match
    import dm_store_buffer_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int AW    = SB_AW,
    parameter int PW    = sb_ptr_w(DEPTH)
) (
    input  logic [AW-1:0] entry_addr [DEPTH],
    input  logic [PW-1:0] head,
    input  logic [PW:0]   count,
    input  logic [AW-1:0] ld_addr,
    output logic          hit,
    output logic [PW-1:0] index
);

    logic [PW-1:0] idx;

    // Walk from oldest to youngest so the last match seen is the youngest.
    always_comb begin
        hit   = 1'b0;
        index = '0;
        idx   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PW'(i);
            if (((PW+1)'(i) < count) && (entry_addr[idx] == ld_addr)) begin
                hit   = 1'b1;
                index = idx;
            end
        end
    end

endmodule

// File: rtl/dm_store_buffer.sv
// In-order store FIFO in front of data memory; retires stores on load-free cycles.
module dm_store_buffer
    import dm_store_buffer_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int AW    = SB_AW,
    parameter int DW    = SB_DW
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          st_valid,
    input  logic [AW-1:0] st_addr,
    input  logic [DW-1:0] st_data,
    output logic          st_ready,
    input  logic          ld_req,
    input  logic [AW-1:0] ld_addr,
    output logic [DW-1:0] ld_data,
    output logic          ld_fwd,
    output logic          empty,
    output logic [AW-1:0] dm_addr,
    output logic [DW-1:0] dm_din,
    output logic          dm_we,
    input  logic [DW-1:0] dm_dout
);

    localparam int PW = sb_ptr_w(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0] addr_q [DEPTH];
    logic [AW-1:0] addr_d [DEPTH];
    logic [DW-1:0] data_q [DEPTH];
    logic [DW-1:0] data_d [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic          push;
    logic          drain;
    logic          hit;
    logic [PW-1:0] hit_idx;

    assign st_ready = (count_q != CW'(DEPTH));
    assign empty    = (count_q == '0);

    assign push  = st_valid && st_ready;
    assign drain = (count_q != '0) && !ld_req;

    always_comb begin
        addr_d  = addr_q;
        data_d  = data_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q + CW'(push) - CW'(drain);
        if (push) begin
            addr_d[tail_q] = st_addr;
            data_d[tail_q] = st_data;
            tail_d         = tail_q + PW'(1);
        end
        if (drain) begin
            head_d = head_q + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    sb_fwd_match #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .PW    (PW)
    ) u_fwd_match (
        .entry_addr (addr_q),
        .head       (head_q),
        .count      (count_q),
        .ld_addr    (ld_addr),
        .hit        (hit),
        .index      (hit_idx)
    );

    // Loads own the DM address port; the head entry is presented otherwise.
    always_comb begin
        dm_we   = drain;
        dm_addr = ld_req ? ld_addr : addr_q[head_q];
        dm_din  = data_q[head_q];
        ld_fwd  = ld_req && hit;
        ld_data = ld_fwd ? data_q[hit_idx] : dm_dout;
    end

endmodule

// File: tb/tb_dm_store_buffer.sv
// Self-checking bench: queue scoreboard of accepted stores plus a behavioural DM.
module tb_dm_store_buffer;

    localparam int AW = 8;
    localparam int DW = 16;
    localparam int DEPTH = 4;

    logic          clk;
    logic          reset_n;
    logic          st_valid;
    logic [AW-1:0] st_addr;
    logic [DW-1:0] st_data;
    logic          st_ready;
    logic          ld_req;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_data;
    logic          ld_fwd;
    logic          empty;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_din;
    logic          dm_we;
    logic [DW-1:0] dm_dout;

    logic [DW-1:0] dm_mem [256];
    logic [AW+DW-1:0] sb_q [$];

    int n_checks = 0;
    int n_errors = 0;

    dm_store_buffer u_dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .st_valid (st_valid),
        .st_addr  (st_addr),
        .st_data  (st_data),
        .st_ready (st_ready),
        .ld_req   (ld_req),
        .ld_addr  (ld_addr),
        .ld_data  (ld_data),
        .ld_fwd   (ld_fwd),
        .empty    (empty),
        .dm_addr  (dm_addr),
        .dm_din   (dm_din),
        .dm_we    (dm_we),
        .dm_dout  (dm_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign dm_dout = dm_mem[dm_addr];

    always @(posedge clk) begin
        if (dm_we) dm_mem[dm_addr] <= dm_din;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Scoreboard: accepted stores queued in order; every DM write and load checked.
    always @(negedge clk) begin
        logic [AW+DW-1:0] e;
        logic [DW-1:0]    exp_ld;
        logic             exp_fwd;
        if (!reset_n) begin
            sb_q.delete();
        end else begin
            chk("st_ready", st_ready, sb_q.size() != DEPTH);
            chk("empty", empty, sb_q.size() == 0);
            chk("dm_we", dm_we, (sb_q.size() != 0) && !ld_req);
            if (ld_req) begin
                exp_ld  = dm_mem[ld_addr];
                exp_fwd = 1'b0;
                foreach (sb_q[i]) begin
                    if (sb_q[i][AW+DW-1:DW] == ld_addr) begin
                        exp_ld  = sb_q[i][DW-1:0];
                        exp_fwd = 1'b1;
                    end
                end
                chk("ld_dm_addr", dm_addr, ld_addr);
                chk("ld_data", ld_data, exp_ld);
                chk("ld_fwd", ld_fwd, exp_fwd);
            end
            if (dm_we && sb_q.size() != 0) begin
                e = sb_q.pop_front();
                chk("wr_addr", dm_addr, e[AW+DW-1:DW]);
                chk("wr_data", dm_din, e[DW-1:0]);
            end
            if (st_valid && st_ready) sb_q.push_back({st_addr, st_data});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        st_valid = 1'b0;
        st_addr  = '0;
        st_data  = '0;
        ld_req   = 1'b0;
        ld_addr  = '0;
    endtask

    task automatic store(input logic [AW-1:0] a, input logic [DW-1:0] d);
        st_valid = 1'b1;
        st_addr  = a;
        st_data  = d;
        step();
        st_valid = 1'b0;
    endtask

    task automatic wait_empty();
        for (int i = 0; i < 50 && !empty; i++) @(negedge clk);
        @(negedge clk);
        chk("drain_timeout", empty, 1'b1);
        step();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) dm_mem[i] = 16'hD000 + 16'(i);
        idle_inputs();
        reset_n = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_st_ready", st_ready, 1'b1);
        chk("rst_empty", empty, 1'b1);
        chk("rst_dm_we", dm_we, 1'b0);
        chk("rst_ld_fwd", ld_fwd, 1'b0);
        chk("rst_ld_data", ld_data, dm_mem[dm_addr]);
        step();
        reset_n = 1'b1;
        repeat (2) step();
        @(negedge clk);
        chk("post_rst_dm_we", dm_we, 1'b0);
        step();

        // Single store retires one cycle after push
        store(8'h03, 16'h1234);
        @(negedge clk);
        chk("single_we", dm_we, 1'b1);
        chk("single_addr", dm_addr, 8'h03);
        chk("single_din", dm_din, 16'h1234);
        step();
        @(negedge clk);
        chk("single_empty", empty, 1'b1);
        chk("single_dm3", dm_mem[3], 16'h1234);
        step();

        // Fill with loads held, then stall a fifth store
        ld_req  = 1'b1;
        ld_addr = 8'h40;
        for (int i = 0; i < DEPTH; i++) store(8'h10 + 8'(i), 16'hA000 + 16'(i));
        st_valid = 1'b1;
        st_addr  = 8'h14;
        st_data  = 16'hA004;
        @(negedge clk);
        chk("full_st_ready", st_ready, 1'b0);
        step();
        @(negedge clk);
        chk("full_hold", st_ready, 1'b0);
        step();
        ld_req = 1'b0;
        @(negedge clk);
        chk("drain0_addr", dm_addr, 8'h10);
        for (int i = 0; i < 10 && !st_ready; i++) @(negedge clk);
        step();
        st_valid = 1'b0;
        wait_empty();
        for (int i = 0; i <= DEPTH; i++) chk("fill_dm", dm_mem[8'h10 + i], 16'hA000 + 16'(i));

        // Forwarding from the youngest duplicate
        ld_req  = 1'b1;
        ld_addr = 8'h7F;
        store(8'h05, 16'h0AAA);
        store(8'h05, 16'h0BBB);
        ld_addr = 8'h05;
        @(negedge clk);
        chk("fwd_data", ld_data, 16'h0BBB);
        chk("fwd_flag", ld_fwd, 1'b1);
        step();
        ld_addr = 8'h06;
        @(negedge clk);
        chk("nofwd_data", ld_data, 16'hD006);
        chk("nofwd_flag", ld_fwd, 1'b0);
        step();
        ld_req = 1'b0;
        wait_empty();
        chk("fwd_dm5", dm_mem[5], 16'h0BBB);

        // Store and load to the same address in one cycle
        ld_req   = 1'b1;
        ld_addr  = 8'h02;
        st_valid = 1'b1;
        st_addr  = 8'h02;
        st_data  = 16'h5555;
        @(negedge clk);
        chk("same_cyc_data", ld_data, 16'hD002);
        chk("same_cyc_fwd", ld_fwd, 1'b0);
        step();
        st_valid = 1'b0;
        @(negedge clk);
        chk("next_ld_data", ld_data, 16'h5555);
        chk("next_ld_fwd", ld_fwd, 1'b1);
        step();
        ld_req = 1'b0;
        wait_empty();

        // Reset while draining discards the rest
        ld_req  = 1'b1;
        ld_addr = 8'h7F;
        store(8'h20, 16'h1111);
        store(8'h21, 16'h2222);
        store(8'h22, 16'h3333);
        ld_req = 1'b0;
        step();
        reset_n = 1'b0;
        @(negedge clk);
        chk("rst_mid_empty", empty, 1'b1);
        chk("rst_mid_we", dm_we, 1'b0);
        step();
        reset_n = 1'b1;
        repeat (3) step();
        chk("rst_mid_dm20", dm_mem[8'h20], 16'h1111);
        chk("rst_mid_dm21", dm_mem[8'h21], 16'hD021);
        chk("rst_mid_dm22", dm_mem[8'h22], 16'hD022);

        // Random mix over a small address window
        for (int n = 0; n < 300; n++) begin
            st_valid = 1'($urandom_range(0, 1));
            st_addr  = 8'h30 + 8'($urandom_range(0, 3));
            st_data  = 16'($urandom);
            ld_req   = ($urandom_range(0, 2) == 0);
            ld_addr  = 8'h30 + 8'($urandom_range(0, 3));
            step();
        end
        idle_inputs();
        wait_empty();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
